// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity modes, TX state encoding and frame-length helper.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
        return 32'd1 + data_bits + ((parity != 32'd0) ? 32'd1 : 32'd0) + stop_bits;
    endfunction

endpackage

// File: rtl/usrt_tx_framer_if.sv
// Word handshake between the TX register interface and the framer.
interface usrt_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_Data;
    logic                 i_Valid;
    logic                 o_Ready;

    modport master (
        output i_Data,
        output i_Valid,
        input  o_Ready
    );

    modport slave (
        input  i_Data,
        input  i_Valid,
        output o_Ready
    );
endinterface

// File: rtl/usrt_parity_gen.sv
// Combinational parity for one data word; shared by the TX and RX paths.
module usrt_parity_gen
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] i_Data,
    input  logic [1:0]           i_Mode,
    output logic                 o_Parity
);
    // Even parity is the plain XOR; odd parity inverts it.
    always_comb begin
        o_Parity = (^i_Data) ^ (i_Mode == PAR_ODD);
    end
endmodule

// File: rtl/usrt_tx_framer.sv
// USRT transmit framer: one holding buffer feeding a tick-paced frame serialiser.
module usrt_tx_framer
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic            i_Bit_Tick,
    usrt_tx_framer_if.slave bus,
    output logic            o_Tx_Serial,
    output logic            o_Busy,
    output logic            o_Done
);
    localparam int unsigned FLEN  = frame_len(DATA_BITS, PARITY, STOP_BITS);
    localparam int unsigned CNT_W = $clog2(FLEN + 1);

    // The counter holds the number of bits already put on the line in this frame.
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DATA_END  = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FRAME_END = CNT_W'(FLEN);

    tx_state_t            state_q, state_d;
    logic                 buf_full_q;
    logic [DATA_BITS-1:0] buf_data_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 par_calc;
    logic                 accept;
    logic                 frame_end;
    logic                 load;

    usrt_parity_gen #(
        .DATA_BITS(DATA_BITS)
    ) u_parity_gen (
        .i_Data  (buf_data_q),
        .i_Mode  (2'(PARITY)),
        .o_Parity(par_calc)
    );

    assign accept    = bus.i_Valid && !buf_full_q;
    assign frame_end = i_Bit_Tick && (state_q == STOP) && (cnt_q == CNT_FRAME_END);
    // A start needs a full buffer, so it can never coincide with an accept.
    assign load      = i_Bit_Tick && buf_full_q && ((state_q == IDLE) || frame_end);

    // Holding buffer: filled on accept, released when its word moves to the shifter.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
        end else if (accept) begin
            buf_full_q <= 1'b1;
            buf_data_q <= bus.i_Data;
        end else if (load) begin
            buf_full_q <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: each state names the kind of bit the next tick will emit.
    always_comb begin
        state_d = state_q;
        if (i_Bit_Tick) begin
            unique case (state_q)
                IDLE: begin
                    if (buf_full_q) state_d = DATA;
                end
                DATA: begin
                    if (cnt_q == CNT_DATA_END) begin
                        state_d = (PARITY != 0) ? usrt_pkg::PARITY : STOP;
                    end
                end
                usrt_pkg::PARITY: state_d = STOP;
                STOP: begin
                    if (cnt_q == CNT_FRAME_END) state_d = buf_full_q ? DATA : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: next line level, shifter, bit counter and done pulse.
    always_comb begin
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = frame_end;
        if (load) begin
            tx_d    = 1'b0;
            cnt_d   = CNT_ONE;
            shift_d = buf_data_q;
            par_d   = par_calc;
        end else if (i_Bit_Tick) begin
            unique case (state_q)
                DATA: begin
                    if (MSB_FIRST != 0) begin
                        tx_d    = shift_q[DATA_BITS-1];
                        shift_d = shift_q << 1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end
                usrt_pkg::PARITY: begin
                    tx_d  = par_q;
                    cnt_d = cnt_q + CNT_ONE;
                end
                STOP: begin
                    tx_d  = 1'b1;
                    cnt_d = frame_end ? '0 : cnt_q + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; the line only moves on the update following a tick.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_Ready = !buf_full_q;
    assign o_Tx_Serial = tx_q;
    assign o_Busy      = (state_q != IDLE);
    assign o_Done      = done_q;

endmodule

// File: tb/tb_usrt_tx_framer.sv
// Bench for usrt_tx_framer: three configurations, scoreboarded frame capture.
module tb_usrt_tx_framer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] data_r [3];
    logic [2:0] valid_r;
    logic [2:0] ready_w;
    logic [2:0] busy_w;
    logic [2:0] tx_w;
    logic [2:0] done_w;
    int         tick_period;
    int         n_checks;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame, bit i is the i-th bit period on the line.
    function automatic logic [31:0] model_frame(input logic [7:0] d, input int par,
                                                input int stop, input int msb);
        logic [31:0] v;
        int          i;
        logic        p;
        v = '0;
        p = 1'b0;
        v[0] = 1'b0;
        i = 1;
        for (int k = 0; k < 8; k++) begin
            v[i] = (msb != 0) ? d[7-k] : d[k];
            p = p ^ d[k];
            i++;
        end
        if (par != 0) begin
            v[i] = (par == 2) ? ~p : p;
            i++;
        end
        for (int s = 0; s < stop; s++) begin
            v[i] = 1'b1;
            i++;
        end
        return v;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div >= tick_period - 1) begin
                tick = 1'b1;
                div  = 0;
            end else begin
                tick = 1'b0;
                div++;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P  = (g == 0) ? 1 : (g == 1) ? 2 : 0;
        localparam int S  = (g == 2) ? 2 : 1;
        localparam int M  = (g == 2) ? 1 : 0;
        localparam int FL = 9 + ((P != 0) ? 1 : 0) + S;

        logic        tx;
        logic        busy;
        logic        done;
        logic [31:0] exp_q [$];
        logic [31:0] vec;
        int          n_bits;
        bit          coll;
        int          n_done;
        int          n_acc;
        int          q_len;

        usrt_tx_framer_if #(.DATA_BITS(8)) bus ();

        assign bus.i_Data  = data_r[g];
        assign bus.i_Valid = valid_r[g];
        assign ready_w[g]  = bus.o_Ready;
        assign busy_w[g]   = busy;
        assign tx_w[g]     = tx;
        assign done_w[g]   = done;

        usrt_tx_framer #(
            .DATA_BITS(8),
            .PARITY   (P),
            .STOP_BITS(S),
            .MSB_FIRST(M)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst_n    (rst_n),
            .i_Bit_Tick (tick),
            .bus        (bus),
            .o_Tx_Serial(tx),
            .o_Busy     (busy),
            .o_Done     (done)
        );

        // Push on accept, capture one bit per tick, pop and compare on a full frame.
        initial begin
            coll   = 1'b0;
            n_bits = 0;
            vec    = '0;
            n_done = 0;
            n_acc  = 0;
            q_len  = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    coll   = 1'b0;
                    n_bits = 0;
                end else begin
                    if (done) n_done++;
                    if (valid_r[g] && ready_w[g]) begin
                        exp_q.push_back(model_frame(data_r[g], P, S, M));
                        n_acc++;
                    end
                    if (tick) begin
                        if (!coll) begin
                            if (tx == 1'b0) begin
                                coll   = 1'b1;
                                vec    = '0;
                                n_bits = 1;
                            end
                        end else begin
                            vec[n_bits] = tx;
                            n_bits++;
                            if (n_bits == FL) begin
                                coll = 1'b0;
                                if (exp_q.size() == 0)
                                    check($sformatf("frame%0d_unexpected", g), 32'd1, 32'd0);
                                else
                                    check($sformatf("frame%0d", g), vec, exp_q.pop_front());
                            end
                        end
                    end
                end
                q_len = exp_q.size();
            end
        end
    end

    task automatic send(input int g, input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        data_r[g]  = d;
        valid_r[g] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_w[g] && n < 2000);
        check("send_timeout", 32'(n >= 2000), 32'd0);
        @(posedge clk);
        #1;
        if (!hold) valid_r[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input bit need_ready);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_w[g] || (need_ready && !ready_w[g])) && n < 3000);
        check("idle_timeout", 32'(n >= 3000), 32'd0);
    endtask

    // After a frame: line must stay high and not busy for a while.
    task automatic idle_quiet(input int g, input string tag);
        int bad;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_w[g] !== 1'b1 || busy_w[g] !== 1'b0) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        check("tick_timeout", 32'(cyc >= 1000), 32'd0);
    endtask

    initial begin
        int base;
        int base_acc;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        valid_r     = '0;
        tick_period = 4;
        for (int i = 0; i < 3; i++) data_r[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx_w), 32'h7);
        check("rst_ready", 32'(ready_w), 32'h7);
        check("rst_busy", 32'(busy_w), 32'h0);
        check("rst_done", 32'(done_w), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Even parity, 0xA5.
        base = g_dut[0].n_done;
        send(0, 8'hA5, 1'b0);
        wait_idle(0, 1'b1);
        idle_quiet(0, "a5_quiet");
        check("a5_done_cnt", 32'(g_dut[0].n_done - base), 32'd1);

        // Odd parity, 0x00.
        base = g_dut[1].n_done;
        send(1, 8'h00, 1'b0);
        wait_idle(1, 1'b1);
        idle_quiet(1, "odd_quiet");
        check("odd_done_cnt", 32'(g_dut[1].n_done - base), 32'd1);

        // Back-to-back: second word waits in the buffer, no gap between frames.
        base = g_dut[0].n_done;
        send(0, 8'h3C, 1'b0);
        send(0, 8'hFF, 1'b0);
        @(negedge clk);
        check("b2b_ready_full", 32'(ready_w[0]), 32'd0);
        wait_idle(0, 1'b0);
        check("b2b_ready_after", 32'(ready_w[0]), 32'd1);
        idle_quiet(0, "b2b_quiet");
        check("b2b_done_cnt", 32'(g_dut[0].n_done - base), 32'd2);

        // MSB first, two stop bits, no parity.
        base = g_dut[2].n_done;
        send(2, 8'h81, 1'b0);
        wait_idle(2, 1'b1);
        idle_quiet(2, "msb_quiet");
        check("msb_done_cnt", 32'(g_dut[2].n_done - base), 32'd1);

        // Backpressure: valid held across three words.
        base     = g_dut[0].n_done;
        base_acc = g_dut[0].n_acc;
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        send(0, 8'h33, 1'b0);
        wait_idle(0, 1'b1);
        idle_quiet(0, "bp_quiet");
        check("bp_accepts", 32'(g_dut[0].n_acc - base_acc), 32'd3);
        check("bp_done_cnt", 32'(g_dut[0].n_done - base), 32'd3);

        // One bit per clock.
        tick_period = 1;
        base = g_dut[0].n_done;
        send(0, 8'h5A, 1'b0);
        wait_idle(0, 1'b1);
        idle_quiet(0, "fast_quiet");
        check("fast_done_cnt", 32'(g_dut[0].n_done - base), 32'd1);
        tick_period = 4;
        repeat (4) @(negedge clk);

        // Reset during the fourth data bit.
        base = g_dut[0].n_done;
        send(0, 8'h96, 1'b0);
        while (!busy_w[0]) @(negedge clk);
        wait_ticks(4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tx", 32'(tx_w[0]), 32'd1);
        check("rst_mid_ready", 32'(ready_w[0]), 32'd1);
        check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_mid_no_done", 32'(g_dut[0].n_done - base), 32'd0);
        base = g_dut[0].n_done;
        send(0, 8'h55, 1'b0);
        wait_idle(0, 1'b1);
        idle_quiet(0, "post_rst_quiet");
        check("post_rst_done_cnt", 32'(g_dut[0].n_done - base), 32'd1);

        check("q_empty0", 32'(g_dut[0].q_len), 32'd0);
        check("q_empty1", 32'(g_dut[1].q_len), 32'd0);
        check("q_empty2", 32'(g_dut[2].q_len), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
